// File: rtl/fifo_data_width_conversion.sv
// Purpose: registered lookup-table converter, Celsius <-> Fahrenheit, on 8-bit integer temperatures.
// Latency: two rising edges (address register, then output register); one new input per cycle.
// Backpressure: none; free-running datapath that always accepts and always presents a result.
module fifo_data_width_conversion #(
  // ROM address is {unit, temperature}, so this must be DATA_WIDTH+1
  parameter int ADDR_WIDTH = 9,
  parameter int DATA_WIDTH = 8
) (
  input  logic                  clk_i,
  input  logic                  rst_ni,
  input  logic [DATA_WIDTH-1:0] temperature_i,
  input  logic                  unit_i,
  output logic [DATA_WIDTH-1:0] temperature_o
);

  localparam int ROM_DEPTH = 2 ** ADDR_WIDTH;
  localparam int HALF      = 2 ** DATA_WIDTH;

  // Contents of one ROM entry. The lower half holds C->F values, the upper half F->C.
  // Inputs are clamped to the physically meaningful range (0..100 C, 32..212 F), and
  // the +2/5 and +4/9 offsets give round-to-nearest. Denominators 5 and 9 never
  // produce an exact half, so there is no tie to break.
  function automatic logic [DATA_WIDTH-1:0] rom_entry(input int addr);
    int t;
    int r;
    t = addr % HALF;
    if (addr >= HALF) begin
      if (t < 32)  t = 32;
      if (t > 212) t = 212;
      r = (5 * (t - 32) + 4) / 9;
    end else begin
      if (t > 100) t = 100;
      r = (9 * t + 2) / 5 + 32;
    end
    return DATA_WIDTH'(r);
  endfunction

  logic [DATA_WIDTH-1:0] rom [ROM_DEPTH];
  logic [ADDR_WIDTH-1:0] addr_q;

  // Fill every ROM entry with an elaboration-time constant
  for (genvar i = 0; i < ROM_DEPTH; i++) begin : g_rom
    localparam logic [DATA_WIDTH-1:0] ENTRY = rom_entry(i);
    assign rom[i] = ENTRY;
  end

  // Stage 1: capture the lookup address; reset parks it at entry 0
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      addr_q <= '0;
    end else begin
      addr_q <= {unit_i, temperature_i};
    end
  end

  // Stage 2: register the ROM output; reset drops any in-flight result
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      temperature_o <= '0;
    end else begin
      temperature_o <= rom[addr_q];
    end
  end

endmodule

// File: tb/tb_fifo_data_width_conversion.sv
// Purpose: self-checking bench for fifo_data_width_conversion with a queue-based scoreboard.
// Latency: expects each result two rising edges after its input is captured.
// Backpressure: none; the monitor pops one expected value per edge once the pipe is primed.
module tb_fifo_data_width_conversion;

  logic       clk_i;
  logic       rst_ni;
  logic [7:0] temperature_i;
  logic       unit_i;
  logic [7:0] temperature_o;

  int n_checks = 0;
  int n_fail   = 0;
  int edge_cnt = 0;
  bit done     = 0;
  logic [7:0] exp_q[$];

  fifo_data_width_conversion #(.ADDR_WIDTH(9), .DATA_WIDTH(8)) dut (
    .clk_i         (clk_i),
    .rst_ni        (rst_ni),
    .temperature_i (temperature_i),
    .unit_i        (unit_i),
    .temperature_o (temperature_o)
  );

  initial clk_i = 1'b0;
  always #5 clk_i = ~clk_i;

  // Reference: real-valued conversion with clamping, rounded to nearest
  function automatic logic [7:0] ref_conv(input int t, input bit u);
    real r;
    int  v;
    if (!u) begin
      v = (t > 100) ? 100 : t;
      r = v * 9.0 / 5.0 + 32.0;
    end else begin
      v = (t < 32) ? 32 : ((t > 212) ? 212 : t);
      r = (v - 32) * 5.0 / 9.0;
    end
    return 8'($rtoi(r + 0.5));
  endfunction

  task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s at %0t: got %0d, expected %0d", name, $time, act, exp);
    end
  endtask

  // Drive one input at the falling edge; record its expected result if out of reset
  task automatic drive(input int t, input bit u, input logic [7:0] e);
    @(negedge clk_i);
    temperature_i = 8'(t);
    unit_i        = u;
    if (rst_ni) exp_q.push_back(e);
  endtask

  task automatic drive_model(input int t, input bit u);
    drive(t, u, ref_conv(t, u));
  endtask

  // Monitor: sample just after each rising edge
  always @(posedge clk_i) begin
    #1;
    if (!done) begin
      if (!rst_ni) begin
        edge_cnt = 0;
        check("reset_hold", temperature_o, 8'd0);
      end else begin
        edge_cnt++;
        if (edge_cnt == 1) begin
          check("first_edge_rom0", temperature_o, 8'd32);
        end else if (exp_q.size() == 0) begin
          n_checks++;
          n_fail++;
          $display("FAIL scoreboard_underflow at %0t: got %0d, expected none", $time, temperature_o);
        end else begin
          check("data", temperature_o, exp_q.pop_front());
        end
      end
    end
  end

  typedef struct { int t; bit u; logic [7:0] e; } vec_t;
  vec_t vecs[$];

  initial begin
    rst_ni        = 1'b1;
    temperature_i = 8'd50;
    unit_i        = 1'b0;
    #1 rst_ni = 1'b0;
    #1 check("reset_async", temperature_o, 8'd0);
    repeat (4) @(posedge clk_i);

    // Release with 50 C applied: 122 F two edges later
    @(negedge clk_i);
    rst_ni = 1'b1;
    exp_q.push_back(8'd122);
    drive(50, 0, 8'd122);

    // Directed vectors: examples, clamps, pipelining, unit toggling
    vecs = '{
      '{0,0,8'd32},  '{1,0,8'd34},  '{37,0,8'd99}, '{40,0,8'd104}, '{100,0,8'd212},
      '{32,1,8'd0},  '{33,1,8'd1},  '{50,1,8'd10}, '{98,1,8'd37},   '{100,1,8'd38},
      '{212,1,8'd100},
      '{150,0,8'd212}, '{255,0,8'd212}, '{0,1,8'd0}, '{31,1,8'd0},
      '{213,1,8'd100}, '{255,1,8'd100},
      '{0,0,8'd32}, '{10,0,8'd50}, '{20,0,8'd68}, '{30,0,8'd86},
      '{100,0,8'd212}, '{100,1,8'd38}, '{100,0,8'd212}, '{100,1,8'd38}
    };
    foreach (vecs[i]) drive(vecs[i].t, vecs[i].u, vecs[i].e);

    // Full sweeps, each value held two cycles
    for (int c = 0; c <= 100; c++) repeat (2) drive_model(c, 0);
    for (int f = 32; f <= 212; f++) repeat (2) drive_model(f, 1);

    // Random stream
    for (int i = 0; i < 200; i++) drive_model($urandom_range(0, 255), 1'($urandom_range(0, 1)));

    // Mid-stream reset: in-flight results are discarded
    @(negedge clk_i);
    rst_ni = 1'b0;
    exp_q.delete();
    #1 check("midstream_reset_async", temperature_o, 8'd0);
    for (int i = 0; i < 2; i++) drive_model($urandom_range(0, 255), 1'($urandom_range(0, 1)));
    @(negedge clk_i);
    rst_ni = 1'b1;
    temperature_i = 8'd100;
    unit_i = 1'b1;
    exp_q.push_back(8'd38);

    for (int i = 0; i < 200; i++) drive_model($urandom_range(0, 255), 1'($urandom_range(0, 1)));

    // Let the last two results emerge
    @(posedge clk_i);
    @(posedge clk_i);
    #3;
    done = 1;
    n_checks++;
    if (exp_q.size() != 0) begin
      n_fail++;
      $display("FAIL drain: got %0d entries left, expected 0", exp_q.size());
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
